// File: rtl/alu_pkg.sv
// Shared definitions for the multicycle ALU: operation codes, FSM states and
// the constants used by the iterative multiply/divide unit.
package alu_pkg;

  localparam logic [4:0] ALU_OP_AND   = 5'b00000;
  localparam logic [4:0] ALU_OP_OR    = 5'b00001;
  localparam logic [4:0] ALU_OP_NOR   = 5'b00010;
  localparam logic [4:0] ALU_OP_ADD   = 5'b00011;
  localparam logic [4:0] ALU_OP_SLL   = 5'b00100;
  localparam logic [4:0] ALU_OP_SRL   = 5'b00101;
  localparam logic [4:0] ALU_OP_SRA   = 5'b00110;
  localparam logic [4:0] ALU_OP_ORI   = 5'b00111;
  localparam logic [4:0] ALU_OP_LUI   = 5'b01000;
  localparam logic [4:0] ALU_OP_SUB   = 5'b01001;
  localparam logic [4:0] ALU_OP_SLT   = 5'b01010;
  localparam logic [4:0] ALU_OP_SLTU  = 5'b01011;
  localparam logic [4:0] ALU_OP_MULT  = 5'b01100;
  localparam logic [4:0] ALU_OP_MULTU = 5'b01101;
  localparam logic [4:0] ALU_OP_DIV   = 5'b01110;
  localparam logic [4:0] ALU_OP_DIVU  = 5'b01111;
  localparam logic [4:0] ALU_OP_XOR   = 5'b10000;
  localparam logic [4:0] ALU_OP_MFHI  = 5'b10001;
  localparam logic [4:0] ALU_OP_MFLO  = 5'b10010;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_MUL  = 2'b01,
    ST_DIV  = 2'b10,
    ST_FIX  = 2'b11
  } alu_state_e;

  // Divide by zero returns an all-ones quotient of whatever width the datapath has.
  localparam logic DIV0_QUOT_FILL = 1'b1;

  // MULT, MULTU, DIV and DIVU share the 011xx code block.
  function automatic logic is_iter_op(input logic [4:0] op);
    return (op[4:2] == 3'b011);
  endfunction

endpackage

// File: rtl/multicycle_alu_if.sv
// Operand/result bus of the multicycle ALU with valid/ready handshake.
interface multicycle_alu_if #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
);

  logic               in_valid;
  logic               in_ready;
  logic [4:0]         alu_op;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic [SHAMT_W-1:0] shamt;
  logic               out_valid;
  logic [WIDTH-1:0]   result;
  logic               zero;
  logic               overflow;
  logic [WIDTH-1:0]   hi;
  logic [WIDTH-1:0]   lo;

  modport master (
    output in_valid, alu_op, a, b, shamt,
    input  in_ready, out_valid, result, zero, overflow, hi, lo
  );

  modport slave (
    input  in_valid, alu_op, a, b, shamt,
    output in_ready, out_valid, result, zero, overflow, hi, lo
  );

endinterface

// File: rtl/mul_div_iter.sv
// Iterative shift-add multiplier / restoring divider working on operand
// magnitudes, with sign fix-up applied to the final registers.
module mul_div_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_div,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  logic                 busy_r;
  logic [CNT_W-1:0]     cnt_r;
  logic                 is_div_r;
  logic                 neg_q_r;
  logic                 neg_r_r;
  logic                 div0_r;
  logic [WIDTH-1:0]     a_raw_r;
  logic [WIDTH-1:0]     opnd_r;
  logic [2*WIDTH-1:0]   acc_r;

  logic [WIDTH-1:0]     a_mag_s;
  logic [WIDTH-1:0]     b_mag_s;
  logic [WIDTH:0]       mul_sum_s;
  logic [2*WIDTH-1:0]   mul_next_s;
  logic [WIDTH:0]       div_shift_s;
  logic [WIDTH:0]       div_diff_s;
  logic [2*WIDTH-1:0]   div_next_s;
  logic [2*WIDTH-1:0]   prod_fix_s;

  assign a_mag_s = (is_signed && a[WIDTH-1]) ? (~a + WIDTH'(1)) : a;
  assign b_mag_s = (is_signed && b[WIDTH-1]) ? (~b + WIDTH'(1)) : b;

  // acc_r holds {partial product, multiplier} or {remainder, quotient} depending on the op.
  assign mul_sum_s   = acc_r[0] ? ({1'b0, acc_r[2*WIDTH-1:WIDTH]} + {1'b0, opnd_r})
                                : {1'b0, acc_r[2*WIDTH-1:WIDTH]};
  assign mul_next_s  = {mul_sum_s, acc_r[WIDTH-1:1]};
  assign div_shift_s = acc_r[2*WIDTH-1:WIDTH-1];
  assign div_diff_s  = div_shift_s - {1'b0, opnd_r};
  assign div_next_s  = div_diff_s[WIDTH] ? {div_shift_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b0}
                                         : {div_diff_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b1};

  assign prod_fix_s  = neg_q_r ? (~acc_r + (2*WIDTH)'(1)) : acc_r;

  // done flags the final iteration; hi_out/lo_out are valid from the next cycle on.
  assign done = busy_r && (cnt_r == LAST_CNT);

  // Operand capture on start, then one multiply or divide step per cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_r   <= 1'b0;
      cnt_r    <= '0;
      is_div_r <= 1'b0;
      neg_q_r  <= 1'b0;
      neg_r_r  <= 1'b0;
      div0_r   <= 1'b0;
      a_raw_r  <= '0;
      opnd_r   <= '0;
      acc_r    <= '0;
    end else if (start) begin
      busy_r   <= 1'b1;
      cnt_r    <= '0;
      is_div_r <= is_div;
      neg_q_r  <= is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
      neg_r_r  <= is_signed && a[WIDTH-1];
      div0_r   <= is_div && (b == '0);
      a_raw_r  <= a;
      opnd_r   <= is_div ? b_mag_s : a_mag_s;
      acc_r    <= {{WIDTH{1'b0}}, (is_div ? a_mag_s : b_mag_s)};
    end else if (busy_r) begin
      acc_r  <= is_div_r ? div_next_s : mul_next_s;
      cnt_r  <= cnt_r + CNT_W'(1);
      busy_r <= (cnt_r != LAST_CNT);
    end else begin
      busy_r <= 1'b0;
    end
  end

  // Sign correction and divide-by-zero override of the finished magnitudes.
  always_comb begin
    hi_out = '0;
    lo_out = '0;
    if (div0_r) begin
      hi_out = a_raw_r;
      lo_out = {WIDTH{DIV0_QUOT_FILL}};
    end else if (is_div_r) begin
      lo_out = neg_q_r ? (~acc_r[WIDTH-1:0] + WIDTH'(1)) : acc_r[WIDTH-1:0];
      hi_out = neg_r_r ? (~acc_r[2*WIDTH-1:WIDTH] + WIDTH'(1)) : acc_r[2*WIDTH-1:WIDTH];
    end else begin
      hi_out = prod_fix_s[2*WIDTH-1:WIDTH];
      lo_out = prod_fix_s[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/multicycle_alu.sv
// EX-stage ALU: single-cycle logic/arith/shift ops plus iterative MULT/DIV
// writing the HI/LO pair, all behind a valid/ready handshake.
module multicycle_alu
  import alu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  multicycle_alu_if.slave  bus
);

  alu_state_e         state_r;
  alu_state_e         next_state_s;
  logic               accept_s;
  logic               start_s;
  logic               fix_s;

  logic [SHAMT_W-1:0] shamt_s;
  logic [WIDTH-1:0]   sum_s;
  logic [WIDTH-1:0]   diff_s;
  logic signed [WIDTH-1:0] sra_s;
  logic [WIDTH-1:0]   alu_res_s;
  logic               alu_ovf_s;

  logic               iter_done_s;
  logic [WIDTH-1:0]   iter_hi_s;
  logic [WIDTH-1:0]   iter_lo_s;

  logic [WIDTH-1:0]   result_r;
  logic               zero_r;
  logic               overflow_r;
  logic               out_valid_r;
  logic [WIDTH-1:0]   hi_r;
  logic [WIDTH-1:0]   lo_r;

  assign shamt_s = bus.shamt;
  assign sum_s   = bus.a + bus.b;
  assign diff_s  = bus.a - bus.b;
  assign sra_s   = $signed(bus.b) >>> shamt_s;

  mul_div_iter #(.WIDTH(WIDTH)) u_mul_div (
    .clk       (clk),
    .reset     (reset),
    .start     (start_s),
    .is_div    (bus.alu_op[1]),
    .is_signed (~bus.alu_op[0]),
    .a         (bus.a),
    .b         (bus.b),
    .done      (iter_done_s),
    .hi_out    (iter_hi_s),
    .lo_out    (iter_lo_s)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Handshake and next-state decode.
  always_comb begin
    next_state_s = state_r;
    accept_s     = 1'b0;
    start_s      = 1'b0;
    fix_s        = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.in_valid) begin
          accept_s = 1'b1;
          if (is_iter_op(bus.alu_op)) begin
            start_s      = 1'b1;
            next_state_s = bus.alu_op[1] ? ST_DIV : ST_MUL;
          end else begin
            next_state_s = ST_IDLE;
          end
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_MUL, ST_DIV: begin
        if (iter_done_s) begin
          next_state_s = ST_FIX;
        end else begin
          next_state_s = state_r;
        end
      end
      ST_FIX: begin
        fix_s        = 1'b1;
        next_state_s = ST_IDLE;
      end
      default: begin
        next_state_s = ST_IDLE;
      end
    endcase
  end

  // Single-cycle datapath; iterative and undefined codes yield zero here.
  always_comb begin
    alu_res_s = '0;
    alu_ovf_s = 1'b0;
    case (bus.alu_op)
      ALU_OP_AND:  alu_res_s = bus.a & bus.b;
      ALU_OP_OR,
      ALU_OP_ORI:  alu_res_s = bus.a | bus.b;
      ALU_OP_NOR:  alu_res_s = ~(bus.a | bus.b);
      ALU_OP_XOR:  alu_res_s = bus.a ^ bus.b;
      ALU_OP_ADD: begin
        alu_res_s = sum_s;
        alu_ovf_s = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (sum_s[WIDTH-1] != bus.a[WIDTH-1]);
      end
      ALU_OP_SUB: begin
        alu_res_s = diff_s;
        alu_ovf_s = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (diff_s[WIDTH-1] != bus.a[WIDTH-1]);
      end
      ALU_OP_SLT:  alu_res_s = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
      ALU_OP_SLTU: alu_res_s = {{(WIDTH-1){1'b0}}, (bus.a < bus.b)};
      ALU_OP_SLL:  alu_res_s = bus.b << shamt_s;
      ALU_OP_SRL:  alu_res_s = bus.b >> shamt_s;
      ALU_OP_SRA:  alu_res_s = sra_s;
      ALU_OP_LUI:  alu_res_s = {bus.b[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
      ALU_OP_MFHI: alu_res_s = hi_r;
      ALU_OP_MFLO: alu_res_s = lo_r;
      ALU_OP_MULT, ALU_OP_MULTU,
      ALU_OP_DIV,  ALU_OP_DIVU: alu_res_s = '0;
      default:     alu_res_s = '0;
    endcase
  end

  // Output and HI/LO registers; HI/LO only move in the FIX cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      result_r    <= '0;
      zero_r      <= 1'b1;
      overflow_r  <= 1'b0;
      out_valid_r <= 1'b0;
      hi_r        <= '0;
      lo_r        <= '0;
    end else if (fix_s) begin
      result_r    <= iter_lo_s;
      zero_r      <= (iter_lo_s == '0);
      overflow_r  <= 1'b0;
      out_valid_r <= 1'b1;
      hi_r        <= iter_hi_s;
      lo_r        <= iter_lo_s;
    end else if (accept_s && !start_s) begin
      result_r    <= alu_res_s;
      zero_r      <= (alu_res_s == '0);
      overflow_r  <= alu_ovf_s;
      out_valid_r <= 1'b1;
    end else begin
      out_valid_r <= 1'b0;
    end
  end

  assign bus.in_ready  = (state_r == ST_IDLE);
  assign bus.out_valid = out_valid_r;
  assign bus.result    = result_r;
  assign bus.zero      = zero_r;
  assign bus.overflow  = overflow_r;
  assign bus.hi        = hi_r;
  assign bus.lo        = lo_r;

endmodule

// File: tb/tb_multicycle_alu.sv
// Self-checking bench for multicycle_alu (WIDTH=32): directed cases plus
// randomized ops against a plain-arithmetic reference model.
module tb_multicycle_alu;
  import alu_pkg::*;

  localparam int WIDTH = 32;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  multicycle_alu_if #(.WIDTH(WIDTH)) bus();

  multicycle_alu #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int tests_run    = 0;
  int tests_failed = 0;
  logic [31:0] model_hi = 32'd0;
  logic [31:0] model_lo = 32'd0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: results straight from the arithmetic rules, 64-bit wide.
  task automatic model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] sh, output logic [31:0] res, output logic ovf);
    longint sa, sb, s;
    logic [63:0] p;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    res = 32'd0;
    ovf = 1'b0;
    case (op)
      ALU_OP_AND:  res = a & b;
      ALU_OP_OR, ALU_OP_ORI: res = a | b;
      ALU_OP_NOR:  res = ~(a | b);
      ALU_OP_XOR:  res = a ^ b;
      ALU_OP_ADD:  begin s = sa + sb; res = s[31:0]; ovf = (s != longint'(int'(s))); end
      ALU_OP_SUB:  begin s = sa - sb; res = s[31:0]; ovf = (s != longint'(int'(s))); end
      ALU_OP_SLT:  res = (sa < sb) ? 32'd1 : 32'd0;
      ALU_OP_SLTU: res = (a < b) ? 32'd1 : 32'd0;
      ALU_OP_SLL:  res = b << sh;
      ALU_OP_SRL:  res = b >> sh;
      ALU_OP_SRA:  begin s = sb >>> sh; res = s[31:0]; end
      ALU_OP_LUI:  res = b * 32'd65536;
      ALU_OP_MFHI: res = model_hi;
      ALU_OP_MFLO: res = model_lo;
      ALU_OP_MULT: begin s = sa * sb; model_hi = s[63:32]; model_lo = s[31:0]; res = model_lo; end
      ALU_OP_MULTU: begin
        p = {32'd0, a} * {32'd0, b};
        model_hi = p[63:32]; model_lo = p[31:0]; res = model_lo;
      end
      ALU_OP_DIV: begin
        if (b == 32'd0) begin
          model_hi = a; model_lo = 32'hFFFF_FFFF;
        end else begin
          s = sa / sb; model_lo = s[31:0];
          s = sa % sb; model_hi = s[31:0];
        end
        res = model_lo;
      end
      ALU_OP_DIVU: begin
        if (b == 32'd0) begin
          model_hi = a; model_lo = 32'hFFFF_FFFF;
        end else begin
          model_lo = a / b; model_hi = a % b;
        end
        res = model_lo;
      end
      default: res = 32'd0;
    endcase
  endtask

  // Issue one op at a negedge and wait (bounded) for its out_valid pulse.
  task automatic do_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] sh, input bit garbage, input string tag);
    logic [31:0] e_res;
    logic        e_ovf;
    int          lat, exp_lat;
    bit          seen, busy_ok;
    exp_lat = (op >= ALU_OP_MULT && op <= ALU_OP_DIVU) ? 34 : 1;
    check_eq({tag, "/in_ready"}, 64'(bus.in_ready), 64'd1);
    model(op, a, b, sh, e_res, e_ovf);
    bus.alu_op = op; bus.a = a; bus.b = b; bus.shamt = sh; bus.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    lat = 1; seen = 1'b0; busy_ok = 1'b1;
    while (!seen && lat <= 200) begin
      if (bus.out_valid === 1'b1) begin
        seen = 1'b1;
      end else begin
        if (bus.in_ready !== 1'b0) busy_ok = 1'b0;
        if (garbage) begin
          bus.in_valid = 1'b1;
          bus.alu_op   = 5'($urandom_range(0, 31));
          bus.a        = $urandom;
          bus.b        = $urandom;
        end else begin
          bus.in_valid = 1'b0;
        end
        @(negedge clk);
        lat++;
      end
    end
    bus.in_valid = 1'b0;
    check_eq({tag, "/out_valid"}, 64'(seen), 64'd1);
    check_eq({tag, "/latency"}, 64'(lat), 64'(exp_lat));
    check_eq({tag, "/result"}, 64'(bus.result), 64'(e_res));
    check_eq({tag, "/zero"}, 64'(bus.zero), 64'(e_res == 32'd0));
    check_eq({tag, "/overflow"}, 64'(bus.overflow), 64'(e_ovf));
    check_eq({tag, "/hi"}, 64'(bus.hi), 64'(model_hi));
    check_eq({tag, "/lo"}, 64'(bus.lo), 64'(model_lo));
    if (exp_lat > 1) begin
      check_eq({tag, "/busy"}, 64'(busy_ok), 64'd1);
      check_eq({tag, "/ready_at_done"}, 64'(bus.in_ready), 64'd1);
    end
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  logic [4:0] op_table [20] = '{
    ALU_OP_AND, ALU_OP_OR, ALU_OP_NOR, ALU_OP_ADD, ALU_OP_SLL, ALU_OP_SRL, ALU_OP_SRA,
    ALU_OP_ORI, ALU_OP_LUI, ALU_OP_SUB, ALU_OP_SLT, ALU_OP_SLTU, ALU_OP_MULT, ALU_OP_MULTU,
    ALU_OP_DIV, ALU_OP_DIVU, ALU_OP_XOR, ALU_OP_MFHI, ALU_OP_MFLO, 5'b11010
  };

  initial begin
    bit ov_seen;
    reset = 1'b1;
    bus.in_valid = 1'b0; bus.alu_op = 5'd0; bus.a = 32'd0; bus.b = 32'd0; bus.shamt = 5'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    check_eq("rst/in_ready", 64'(bus.in_ready), 64'd1);
    check_eq("rst/out_valid", 64'(bus.out_valid), 64'd0);
    check_eq("rst/result", 64'(bus.result), 64'd0);
    check_eq("rst/zero", 64'(bus.zero), 64'd1);
    check_eq("rst/overflow", 64'(bus.overflow), 64'd0);
    check_eq("rst/hi", 64'(bus.hi), 64'd0);
    check_eq("rst/lo", 64'(bus.lo), 64'd0);

    do_op(ALU_OP_ADD,  32'h7FFF_FFFF, 32'd1, 5'd0, 1'b0, "add_ovf");
    do_op(ALU_OP_SUB,  32'd5, 32'd5, 5'd0, 1'b0, "sub_zero");
    do_op(ALU_OP_SRA,  32'd0, 32'h8000_0000, 5'd4, 1'b0, "sra");
    do_op(ALU_OP_SLTU, 32'd1, 32'hFFFF_FFFF, 5'd0, 1'b0, "sltu");
    do_op(ALU_OP_SLT,  32'd1, 32'hFFFF_FFFF, 5'd0, 1'b0, "slt");
    do_op(ALU_OP_LUI,  32'd0, 32'h0000_1234, 5'd0, 1'b0, "lui");
    do_op(ALU_OP_MULT, 32'hFFFF_FFFE, 32'd3, 5'd0, 1'b1, "mult");
    check_eq("mult/hi_const", 64'(bus.hi), 64'h0000_0000_FFFF_FFFF);
    check_eq("mult/lo_const", 64'(bus.lo), 64'h0000_0000_FFFF_FFFA);
    do_op(ALU_OP_DIV,  32'hFFFF_FFF9, 32'd2, 5'd0, 1'b1, "div");
    check_eq("div/lo_const", 64'(bus.lo), 64'h0000_0000_FFFF_FFFD);
    do_op(ALU_OP_DIVU, 32'd7, 32'd0, 5'd0, 1'b0, "divu0");
    do_op(ALU_OP_MFHI, 32'd0, 32'd0, 5'd0, 1'b0, "mfhi");
    check_eq("mfhi/const", 64'(bus.result), 64'd7);
    do_op(ALU_OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 5'd0, 1'b0, "div_minneg");

    // Abort a DIV with reset ten cycles after accept.
    bus.alu_op = ALU_OP_DIV; bus.a = 32'd100; bus.b = 32'd7; bus.in_valid = 1'b1;
    @(posedge clk);
    bus.in_valid = 1'b0;
    ov_seen = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (bus.out_valid === 1'b1) ov_seen = 1'b1;
    end
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_hi = 32'd0; model_lo = 32'd0;
    check_eq("abort/no_valid", 64'(ov_seen), 64'd0);
    check_eq("abort/out_valid", 64'(bus.out_valid), 64'd0);
    check_eq("abort/in_ready", 64'(bus.in_ready), 64'd1);
    check_eq("abort/hi", 64'(bus.hi), 64'd0);
    check_eq("abort/lo", 64'(bus.lo), 64'd0);
    repeat (40) begin
      @(negedge clk);
      if (bus.out_valid === 1'b1) ov_seen = 1'b1;
    end
    check_eq("abort/late_valid", 64'(ov_seen), 64'd0);
    do_op(ALU_OP_ADD, 32'd20, 32'd22, 5'd0, 1'b0, "add_after_rst");
    do_op(5'b10111, 32'hDEAD_BEEF, 32'h1234_5678, 5'd3, 1'b0, "undef");

    for (int n = 0; n < 80; n++) begin
      do_op(op_table[$urandom_range(0, 19)], pick_operand(), pick_operand(),
            5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), $sformatf("rnd%0d", n));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
